// File: rtl/serial_sub_if.sv
// Handshake bundle for the bit-serial subtractor: operand channel in,
// result channel out, plus the busy status flag.
// master: the side that supplies operands and consumes results.
// slave : the subtractor itself.
interface serial_sub_if #(
   parameter int W = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         borrow;
   logic         busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, diff, borrow, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, diff, borrow, busy
   );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial W-bit unsigned subtractor (a - b), LSB first, one bit per clock.
// A single one-bit subtract cell is reused every cycle; its borrow is kept in
// a flop so the chain runs across cycles. Result is presented through a
// valid/ready handshake and held until the consumer takes it.
// Optional build macro SERIAL_SUB_SAT_EN: when defined, an underflowing
// result (final borrow = 1) is clamped to zero; borrow still reports 1.
module serial_sub #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   serial_sub_if.slave  bus
);
   localparam int CNT_W = $clog2(W) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     a_sh_q, a_sh_d;
   logic [W-1:0]     b_sh_q, b_sh_d;
   logic [W-1:0]     res_q, res_d;
   logic [W-1:0]     diff_q, diff_d;
   logic             br_q, br_d;
   logic             borrow_q, borrow_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_ready_q, out_valid_q, busy_q;
   logic             cell_diff_s, cell_borrow_s;

   // One-bit subtract cell: returns {borrow_out, diff}.
   function automatic logic [1:0] sub_cell(input logic x, input logic y, input logic bin);
      logic d;
      logic bout;
      d    = x ^ y ^ bin;
      bout = (~x & y) | (~(x ^ y) & bin);
      return {bout, d};
   endfunction

   assign {cell_borrow_s, cell_diff_s} = sub_cell(a_sh_q[0], b_sh_q[0], br_q);

   // Next-state and datapath: load in IDLE, one cell step per SHIFT cycle, hold in DONE.
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_d    = res_q;
      diff_d   = diff_q;
      br_d     = br_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               a_sh_d  = bus.a;
               b_sh_d  = bus.b;
               br_d    = 1'b0;
               cnt_d   = {CNT_W{1'b0}};
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            // Cell result enters at the MSB so the word is aligned after W steps.
            res_d  = (res_q >> 1) | (W'(cell_diff_s) << (W - 1));
            br_d   = cell_borrow_s;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(W - 1)) begin
               state_d  = DONE;
               borrow_d = cell_borrow_s;
`ifdef SERIAL_SUB_SAT_EN
               if (cell_borrow_s) begin
                  diff_d = {W{1'b0}};
               end else begin
                  diff_d = (res_q >> 1) | (W'(cell_diff_s) << (W - 1));
               end
`else
               diff_d = (res_q >> 1) | (W'(cell_diff_s) << (W - 1));
`endif
            end else begin
               state_d = SHIFT;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, datapath and registered status outputs (decoded from next state).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         a_sh_q      <= {W{1'b0}};
         b_sh_q      <= {W{1'b0}};
         res_q       <= {W{1'b0}};
         diff_q      <= {W{1'b0}};
         br_q        <= 1'b0;
         borrow_q    <= 1'b0;
         cnt_q       <= {CNT_W{1'b0}};
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         res_q       <= res_d;
         diff_q      <= diff_d;
         br_q        <= br_d;
         borrow_q    <= borrow_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= (state_d == IDLE);
         out_valid_q <= (state_d == DONE);
         busy_q      <= (state_d == SHIFT);
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.diff      = diff_q;
   assign bus.borrow    = borrow_q;
endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub: transaction-level reference model checked every cycle
// on the W=8 instance, plus directed literal expectations for both W=8 and W=1.
module tb_serial_sub;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass = 0;
   int   n_chk  = 0;

   always #5 clk = ~clk;

   serial_sub_if #(.W(W)) bus8 ();
   serial_sub_if #(.W(1)) bus1 ();

   serial_sub #(.W(W)) dut  (.clk(clk), .rst(rst), .bus(bus8));
   serial_sub #(.W(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (act === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
   endtask

   // ---------------- reference model (transaction level) ----------------
   // An operation is in flight from its accepting edge until the handshake
   // edge; the result is visible W edges after acceptance.
   bit           m_inflight = 1'b0;
   int           m_k = 0;
   logic [W-1:0] m_a = '0, m_b = '0;
   logic [W-1:0] m_last_diff = '0;
   logic         m_last_borrow = 1'b0;

   function automatic logic [W:0] model_res(input logic [W-1:0] x, input logic [W-1:0] y);
      int           r;
      logic         bw;
      logic [W-1:0] d;
      r  = int'(x) - int'(y);
      bw = (r < 0);
      d  = W'((r + (1 << W)) % (1 << W));
`ifdef SERIAL_SUB_SAT_EN
      if (bw) d = '0;
`endif
      return {bw, d};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_inflight    = 1'b0;
         m_k           = 0;
         m_last_diff   = '0;
         m_last_borrow = 1'b0;
      end else if (!m_inflight) begin
         if (bus8.in_valid) begin
            m_inflight = 1'b1;
            m_k        = 0;
            m_a        = bus8.a;
            m_b        = bus8.b;
         end
      end else if (m_k >= W && bus8.out_ready) begin
         m_inflight                   = 1'b0;
         {m_last_borrow, m_last_diff} = model_res(m_a, m_b);
      end else if (m_k < W) begin
         m_k = m_k + 1;
      end
   end

   always @(negedge clk) begin
      logic [W:0] r;
      r = model_res(m_a, m_b);
      chk("in_ready",  32'(bus8.in_ready),  32'(!m_inflight));
      chk("busy",      32'(bus8.busy),      32'(m_inflight && m_k < W));
      chk("out_valid", 32'(bus8.out_valid), 32'(m_inflight && m_k >= W));
      if (m_inflight && m_k >= W) begin
         chk("diff",   32'(bus8.diff),   32'(r[W-1:0]));
         chk("borrow", 32'(bus8.borrow), 32'(r[W]));
      end else if (!m_inflight) begin
         chk("diff_held",   32'(bus8.diff),   32'(m_last_diff));
         chk("borrow_held", 32'(bus8.borrow), 32'(m_last_borrow));
      end
   end

   // ---------------- directed stimulus helpers ----------------
   task automatic wait_ready8();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus8.in_ready && n < 50);
      if (!bus8.in_ready) chk("timeout_in_ready", 32'd0, 32'd1);
   endtask

   task automatic wait_valid8();
      int n = 0;
      while (!bus8.out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus8.out_valid) chk("timeout_out_valid", 32'd0, 32'd1);
   endtask

   // One isolated operation with out_ready held high.
   task automatic run_op(input string nm, input int av, input int bv, input int ed, input int eb);
      int lat = 0;
      wait_ready8();
      #1;
      bus8.a = W'(av); bus8.b = W'(bv); bus8.in_valid = 1'b1;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!bus8.out_valid && lat < 40);
      chk({nm, "_latency"}, 32'(lat), 32'(W));
      chk({nm, "_diff"},    32'(bus8.diff),   32'(ed));
      chk({nm, "_borrow"},  32'(bus8.borrow), 32'(eb));
      @(posedge clk); #1;
      chk({nm, "_in_ready_after"}, 32'(bus8.in_ready), 32'd1);
   endtask

   int pa [3] = '{255, 0, 0};
   int pb [3] = '{1, 0, 1};
   int pd [3] = '{254, 0, 255};
   int pw [3] = '{0, 0, 1};

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.out_ready = 1'b1;
      bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.out_ready = 1'b1;

      // Reset values
      @(negedge clk);
      chk("rst_in_ready",  32'(bus8.in_ready),  32'd1);
      chk("rst_out_valid", 32'(bus8.out_valid), 32'd0);
      chk("rst_busy",      32'(bus8.busy),      32'd0);
      chk("rst_diff",      32'(bus8.diff),      32'd0);
      chk("rst_borrow",    32'(bus8.borrow),    32'd0);
      #1 rst = 1'b0;

      // 1: normal subtraction
      run_op("t1", 200, 57, 143, 0);

      // 2: underflow
`ifdef SERIAL_SUB_SAT_EN
      run_op("t2", 57, 200, 0, 1);
`else
      run_op("t2", 57, 200, 113, 1);
`endif

      // 3: edge operands, in_valid held high, operands changed after each accept
      @(negedge clk); #1;
      bus8.a = W'(pa[0]); bus8.b = W'(pb[0]); bus8.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_ready8();
         @(posedge clk); #1;
         if (i < 2) begin
            bus8.a = W'(pa[i+1]); bus8.b = W'(pb[i+1]);
         end else begin
            bus8.in_valid = 1'b0;
         end
         @(negedge clk);
         wait_valid8();
         chk("t3_diff",   32'(bus8.diff),   32'(pd[i]));
         chk("t3_borrow", 32'(bus8.borrow), 32'(pw[i]));
      end

      // 4: backpressure in DONE; a new request must wait
      wait_ready8(); #1;
      bus8.out_ready = 1'b0;
      bus8.a = W'(10); bus8.b = W'(3); bus8.in_valid = 1'b1;
      @(posedge clk); #1;
      bus8.a = W'(99); bus8.b = W'(1);
      @(negedge clk);
      wait_valid8();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_out_valid", 32'(bus8.out_valid), 32'd1);
         chk("t4_diff",      32'(bus8.diff),      32'd7);
         chk("t4_borrow",    32'(bus8.borrow),    32'd0);
         chk("t4_in_ready",  32'(bus8.in_ready),  32'd0);
      end
      #1 bus8.out_ready = 1'b1;
      wait_ready8();
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      @(negedge clk);
      wait_valid8();
      chk("t4_next_diff",   32'(bus8.diff),   32'd98);
      chk("t4_next_borrow", 32'(bus8.borrow), 32'd0);

      // 5: reset 3 cycles into SHIFT
      wait_ready8(); #1;
      bus8.a = W'(100); bus8.b = W'(30); bus8.in_valid = 1'b1;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t5_in_ready",  32'(bus8.in_ready),  32'd1);
      chk("t5_out_valid", 32'(bus8.out_valid), 32'd0);
      chk("t5_busy",      32'(bus8.busy),      32'd0);
      chk("t5_diff",      32'(bus8.diff),      32'd0);
      chk("t5_borrow",    32'(bus8.borrow),    32'd0);
      @(negedge clk); #1 rst = 1'b0;
      run_op("t5_after", 100, 30, 70, 0);

      // 6: W=1 instance, all four input pairs, 1-cycle latency
      for (int i = 0; i < 4; i++) begin
         logic [1:0] ab;
         ab = 2'(i);
         @(negedge clk); #1;
         bus1.a = ab[1]; bus1.b = ab[0]; bus1.in_valid = 1'b1;
         @(posedge clk); #1;
         bus1.in_valid = 1'b0;
         @(posedge clk); #1;
         chk("t6_out_valid", 32'(bus1.out_valid), 32'd1);
         chk("t6_diff",      32'(bus1.diff),      32'(ab[1] ^ ab[0]));
         chk("t6_borrow",    32'(bus1.borrow),    32'(ab == 2'b01));
         @(posedge clk);
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
